// File: rtl/fsm_step_ctrl.sv
// ----------------------------------------------------------------------------
// fsm_step_ctrl
//   Step sequencer for the serial sequence-detector FSM on the lab board.
//   On start it latches a test pattern and issues a one-cycle clear to the
//   detector. It then presents the pattern one bit per step, MSB first. Each
//   step is a one-cycle clock-enable pulse, so the detector never sees a
//   divided clock. Steps come from a divided timebase (auto mode) or from a
//   push-button (manual mode).
//
// Optional feature macro: STEP_DEBOUNCE_EN
//   defined   : the synchronised button must be stable for DEB_CYC cycles
//               before its level is accepted.
//   undefined : edges are taken directly from the 2-FF synchroniser. This is
//               the default build.
//
// Parameters
//   DIV_MAX  clk cycles spent in WAIT before each auto step (>= 2)
//   PAT_W    pattern length in bits (2..16)
//   DEB_CYC  debounce stable time in clk cycles (STEP_DEBOUNCE_EN only)
//
// Ports
//   clk       in   system clock, all logic on the rising edge
//   rst       in   asynchronous reset, active low
//   start     in   level; sampled in IDLE/DONE, latches pattern and starts a run
//   abort     in   level; forces IDLE on the next cycle, wins over start
//   mode      in   0 = auto (timebase), 1 = manual (step_btn)
//   step_btn  in   raw asynchronous push-button
//   pattern   in   bits to feed, bit PAT_W-1 first
//   fsm_clr   out  one-cycle clear to the detector (CLEAR state)
//   step_en   out  one-cycle clock enable to the detector (STEP state)
//   bit_out   out  serial bit to the detector input (MSB of shift register)
//   busy      out  high in CLEAR/WAIT/STEP
//   done      out  high in DONE until start or abort
//   bit_idx   out  index of the bit currently presented
// ----------------------------------------------------------------------------
module fsm_step_ctrl #(
  parameter int DIV_MAX = 25000000,
  parameter int PAT_W   = 8,
  parameter int DEB_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic             step_btn,
  input  logic [PAT_W-1:0] pattern,
  output logic             fsm_clr,
  output logic             step_en,
  output logic             bit_out,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bit_idx
);

  localparam int CNT_W = $clog2(DIV_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MAX - 1);
  localparam logic [3:0]       IDX_LAST = 4'(PAT_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_STEP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [PAT_W-1:0] r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit_idx;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_btn_d;

  logic [2:0]       w_state_nxt;
  logic [PAT_W-1:0] w_sh_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_idx_nxt;
  logic             w_btn_lvl;
  logic             w_btn_rise;

  // Two-flop synchroniser for the raw button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= step_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYC + 1);
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_deb_lvl;

  // Debounce: accept a new level only after it has differed from the
  // accepted level for DEB_CYC consecutive cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb_cnt <= '0;
      r_deb_lvl <= 1'b0;
    end else if (r_sync2 == r_deb_lvl) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_W'(DEB_CYC - 1)) begin
      r_deb_lvl <= r_sync2;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + DEB_W'(1);
    end
  end

  assign w_btn_lvl = r_deb_lvl;
`else
  assign w_btn_lvl = r_sync2;
`endif

  // Previous button level for rising-edge detection. It runs in every state,
  // so an edge outside WAIT is consumed there and never replayed later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn_d <= 1'b0;
    end else begin
      r_btn_d <= w_btn_lvl;
    end
  end

  assign w_btn_rise = w_btn_lvl & ~r_btn_d;

  // Next-state and datapath update; abort overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_bit_idx;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_CLEAR;
          w_sh_nxt    = pattern;
          w_idx_nxt   = 4'd0;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
      end
      S_WAIT: begin
        if (mode) begin
          // Manual mode holds the divider at zero. A later return to auto
          // mode therefore always starts a full WAIT period.
          w_cnt_nxt = '0;
          if (w_btn_rise) begin
            w_state_nxt = S_STEP;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_STEP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STEP: begin
        w_sh_nxt  = {r_sh[PAT_W-2:0], 1'b0};
        w_idx_nxt = r_bit_idx + 4'd1;
        if (r_bit_idx == IDX_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sh_nxt    = '0;
        w_cnt_nxt   = '0;
        w_idx_nxt   = 4'd0;
      end
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_sh_nxt    = '0;
      w_cnt_nxt   = '0;
      w_idx_nxt   = 4'd0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // State, shift register, divider and bit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_bit_idx <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_sh      <= w_sh_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_idx_nxt;
    end
  end

  // Moore outputs registered from the next state, so they align with r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_clr <= 1'b0;
      step_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      fsm_clr <= (w_state_nxt == S_CLEAR);
      step_en <= (w_state_nxt == S_STEP);
      busy    <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_WAIT) ||
                 (w_state_nxt == S_STEP);
      done    <= (w_state_nxt == S_DONE);
    end
  end

  assign bit_out = r_sh[PAT_W-1];
  assign bit_idx = r_bit_idx;

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fsm_step_ctrl
//   Directed bench for fsm_step_ctrl with DIV_MAX=4, PAT_W=4, DEB_CYC=8.
//   A table of per-cycle vectors covers an auto run and the start/abort
//   corners. Hand-written sequences cover manual stepping, button latency,
//   the abort/start collision, mode switching and async reset. Outputs are
//   packed as {fsm_clr, step_en, bit_out, busy, done, bit_idx[3:0]}.
// ----------------------------------------------------------------------------
module tb_fsm_step_ctrl;

  localparam int DIV_MAX = 4;
  localparam int PAT_W   = 4;
  localparam int DEB_CYC = 8;

  localparam logic [8:0] FULL  = 9'h1FF;
  localparam logic [8:0] NOIDX = 9'h1F0;

`ifdef STEP_DEBOUNCE_EN
  localparam int SHORT_PRESS_STEPS = 0;
`else
  localparam int SHORT_PRESS_STEPS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       mode = 1'b0;
  logic       step_btn = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic       fsm_clr;
  logic       step_en;
  logic       bit_out;
  logic       busy;
  logic       done;
  logic [3:0] bit_idx;

  int          n_pass  = 0;
  int          n_total = 0;
  int          pulses  = 0;
  logic [15:0] bits    = 16'h0000;

  typedef struct {
    logic       st;
    logic       ab;
    logic       md;
    logic [3:0] pat;
    logic [8:0] exp;
    logic [8:0] msk;
  } vec_t;

  vec_t tbl[$];

  fsm_step_ctrl #(
    .DIV_MAX(DIV_MAX),
    .PAT_W  (PAT_W),
    .DEB_CYC(DEB_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .mode    (mode),
    .step_btn(step_btn),
    .pattern (pattern),
    .fsm_clr (fsm_clr),
    .step_en (step_en),
    .bit_out (bit_out),
    .busy    (busy),
    .done    (done),
    .bit_idx (bit_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] pk(input logic c, input logic s, input logic b,
                                    input logic y, input logic d, input logic [3:0] i);
    return {c, s, b, y, d, i};
  endfunction

  function automatic vec_t mkv(input logic st, input logic ab, input logic [3:0] pat,
                               input logic [8:0] exp, input logic [8:0] msk);
    vec_t v;
    v.st  = st;
    v.ab  = ab;
    v.md  = 1'b0;
    v.pat = pat;
    v.exp = exp;
    v.msk = msk;
    return v;
  endfunction

  function automatic logic [8:0] cur();
    return {fsm_clr, step_en, bit_out, busy, done, bit_idx};
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp,
                     input logic [8:0] msk);
    n_total++;
    if ((act & msk) === (exp & msk)) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (clr,stp,bit,busy,done,idx)",
               name, act & msk, exp & msk);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Run n cycles, counting step_en pulses and the bit presented at each one.
  task run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (step_en === 1'b1) begin
        pulses++;
        bits = {bits[14:0], bit_out};
      end
    end
  endtask

  task press(input int hi, input int lo);
    step_btn = 1'b1;
    run(hi);
    step_btn = 1'b0;
    run(lo);
  endtask

  initial begin
    logic [3:0] pa;

    // Auto run of 1011. A start and a pattern change during the run are ignored.
    pa = 4'b1011;
    tbl.push_back(mkv(1'b1, 1'b0, 4'b1011, pk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0), FULL));
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 4; w++) begin
        tbl.push_back(mkv((k == 1) && (w == 0), 1'b0, 4'b0101,
                          pk(1'b0, 1'b0, pa[3-k], 1'b1, 1'b0, 4'(k)), FULL));
      end
      tbl.push_back(mkv(1'b0, 1'b0, 4'b0101,
                        pk(1'b0, 1'b1, pa[3-k], 1'b1, 1'b0, 4'(k)), FULL));
    end
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0101, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0), NOIDX));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b0101, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0), NOIDX));
    tbl.push_back(mkv(1'b1, 1'b0, 4'b1000, pk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0), FULL));
    tbl.push_back(mkv(1'b0, 1'b1, 4'b1000, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), FULL));
    tbl.push_back(mkv(1'b1, 1'b1, 4'b1000, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), FULL));
    tbl.push_back(mkv(1'b0, 1'b0, 4'b1000, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), FULL));

    // Reset held for 3 cycles, then released.
    repeat (3) @(negedge clk);
    chk("reset_hold", cur(), 9'h000, FULL);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_release", cur(), 9'h000, FULL);
    pulses = 0;
    run(5);
    chk_int("reset_no_step", pulses, 0);
    chk("reset_idle", cur(), 9'h000, FULL);

    // Table-driven auto run.
    for (int i = 0; i < tbl.size(); i++) begin
      start   = tbl[i].st;
      abort   = tbl[i].ab;
      mode    = tbl[i].md;
      pattern = tbl[i].pat;
      @(negedge clk);
      chk($sformatf("vec%0d", i), cur(), tbl[i].exp, tbl[i].msk);
    end
    start = 1'b0;
    abort = 1'b0;

    // Manual run of 0110 with four 20-cycle presses.
    mode = 1'b1;
    pattern = 4'b0110;
    start = 1'b1;
    @(negedge clk);
    chk("man_clear", cur(), pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0), FULL);
    start = 1'b0;
    pattern = 4'b1111;
    pulses = 0;
    bits = 16'h0000;
    run(10);
    chk_int("man_no_auto_step", pulses, 0);
    for (int p = 0; p < 4; p++) press(20, 20);
    chk_int("man_pulses", pulses, 4);
    chk_int("man_bits", int'(bits[3:0]), 6);
    chk("man_done", cur(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0), NOIDX);

    // Button-to-step latency and a 50-cycle held press.
    pattern = 4'b1001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    step_btn = 1'b1;
    @(negedge clk);
    chk("lat_cycle1", cur(), pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0), FULL);
    @(negedge clk);
    chk("lat_cycle2", cur(), pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0), FULL);
    @(negedge clk);
    chk("lat_cycle3_step", cur(), pk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0), FULL);
    pulses = 0;
    run(47);
    step_btn = 1'b0;
    run(10);
    chk_int("long_press_single", pulses, 0);
    chk("long_press_state", cur(), pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1), FULL);
    pulses = 0;
    press(12, 12);
    chk_int("press_to_idx2", pulses, 1);
    chk("wait_idx2", cur(), pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2), FULL);

    // Abort and start together in WAIT with bit_idx=2: abort wins.
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("abort_start", cur(), 9'h000, FULL);
    abort = 1'b0;
    start = 1'b0;
    pulses = 0;
    run(20);
    chk_int("abort_no_step", pulses, 0);
    chk("abort_idle", cur(), 9'h000, FULL);

    // A press in IDLE must not be replayed once a run starts.
    press(12, 12);
    pattern = 4'b1100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    run(20);
    chk_int("idle_press_discarded", pulses, 0);

    // Mode switch: auto run paused at cnt=2, one manual step, then back to auto.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    mode = 1'b0;
    pattern = 4'b1100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    mode = 1'b1;
    pulses = 0;
    bits = 16'h0000;
    run(20);
    chk_int("switch_no_auto_step", pulses, 0);
    press(12, 12);
    chk_int("switch_manual_step", pulses, 1);
    chk_int("switch_manual_bit", int'(bits[0]), 1);
    mode = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("switch_back_wait%0d", c), cur(),
          pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1), FULL);
    end
    @(negedge clk);
    chk("switch_back_step", cur(), pk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1), FULL);
    mode = 1'b1;

    // Short versus long press.
    pulses = 0;
    press(5, 20);
    chk_int("short_press", pulses, SHORT_PRESS_STEPS);
    pulses = 0;
    press(12, 20);
    chk_int("long_press", pulses, 1);
`ifdef STEP_DEBOUNCE_EN
    chk("press_end_state", cur(), pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3), FULL);
`else
    chk("press_end_state", cur(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0), NOIDX);
`endif

    // Asynchronous reset mid-run, then no clear pulse after release.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    mode = 1'b0;
    pattern = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_async", cur(), 9'h000, FULL);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_no_clr", cur(), 9'h000, FULL);
    pulses = 0;
    run(15);
    chk_int("rst_no_step", pulses, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
